bus_source_encoder: RTL
=======================

Name: bus_source_encoder

Overview:
- Source-side companion to the 32:1 bus multiplexer.
- Turns the control unit's one-hot "Xout" requests into the mux's 5-bit select code.
- Holds the instruction register (IR) copy used for select-and-encode: Gra/Grb/Grc picks an IR register field and drives register out/in strobes.
- Generates the 32-bit sign-extended C constant and detects and counts multi-driver bus conflicts.

Parameters:
- CNT_W, 8: width of the saturating conflict counter.
- IDLE_SEL, 5'd31: select code driven when no source requests the bus. Any code 24..31 makes the mux output 0.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset, asynchronous, active-high.
- out_req  in  24  one-hot source requests. Bit n requests mux code n: 0-15 = R0-R15, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 Csign.
- ir_in  in  32  bus value to capture into the IR copy.
- ir_load  in  1  capture ir_in at the next clock edge.
- gra, grb, grc  in  1 each  select IR field Ra, Rb or Rc.
- r_out  in  1  put the selected register on the bus.
- ba_out  in  1  base-address out; field 0 reads as zero.
- r_in  in  1  load the selected register from the bus.
- select  out  5  mux select code, combinational.
- reg_in  out  16  one-hot register load enables, combinational.
- c_sign_extended  out  32  IR[18:0] sign-extended from bit 18.
- conflict  out  1  registered one-cycle pulse marking a conflict in the previous cycle.
- conflict_sticky  out  1  set on any conflict, cleared by err_clr.
- conflict_count  out  CNT_W  saturating conflict count.
- err_clr  in  1  synchronous clear of conflict_sticky and conflict_count.

Behaviour:
- Reset: clear asserted at any time, including mid-instruction.
  - ir_q=0, conflict=0, conflict_sticky=0, conflict_count=0, all taking effect immediately.
  - Combinational outputs then follow: select=IDLE_SEL when out_req=0; reg_in=0 when r_in=0; c_sign_extended=0.
- IR register: ir_q <= ir_in on a rising edge with ir_load=1, otherwise it holds. New fields are visible from the following cycle.
- Fields: Ra=ir_q[26:23], Rb=ir_q[22:19], Rc=ir_q[18:15].
- Field select: fld = Ra if gra; else Rb if grb; else Rc if grc; else 4'd0. Priority is gra > grb > grc.
- Register strobes:
  - rreq = one-hot(fld) in bits 0-15 when r_out, or when ba_out with fld != 0; otherwise 0.
  - ba_out with fld=0 requests nothing from the register file and forces the bus to zero (see select rules).
- Effective request: eff = out_req | {8'b0, rreq}.
- Select, zero latency:
  - eff=0 gives IDLE_SEL.
  - Otherwise the index of the lowest set bit of eff. Lowest index wins on multiple requests.
  - ba_out with fld=0 and eff=0 gives IDLE_SEL (zero on the bus).
- reg_in = r_in ? one-hot(fld) : 16'b0. Only r_in drives reg_in; r_out/ba_out do not.
- c_sign_extended = {{13{ir_q[18]}}, ir_q[18:0]}.
- Conflict:
  - cf_now = more than one bit of eff set, or ba_out with fld=0 while eff != 0.
  - At each edge: conflict <= cf_now.
  - conflict_sticky <= cf_now | (sticky & ~err_clr). Set wins over err_clr in the same cycle.
  - conflict_count: err_clr loads cf_now (0 or 1). Otherwise it increments on cf_now and saturates at 2^CNT_W-1 with no wrap.
- ir_load and r_out/gra in the same cycle: select uses the old ir_q and the new field applies from the next cycle.

Optional Feature:
- Macro BUS_SOURCE_ENCODER_CONFLICT_COUNT_EN.
- Defined: conflict_count register present as specified.
- Undefined: counter removed; conflict_count tied to 0. conflict and conflict_sticky are unchanged.

Test Plan:
- Reset: assert clear mid-cycle with out_req=24'h000004 -> select=2 stays; conflict/sticky/count=0 immediately; after ir reset c_sign_extended=0.
- IR field decode: ir_in=32'h0118_8000, ir_load, one edge (Ra=2, Rb=3, Rc=1) -> gra+r_out gives select=2; grb+r_in gives reg_in=16'h0008; grc+r_out gives select=1.
- Specials: out_req bit 20 gives select=20; bit 23 with ir_q[18:0]=19'h40005 gives c_sign_extended=32'hFFFC0005; out_req=0 gives select=31.
- BAout zero: Ra=0, gra+ba_out, out_req=0 -> select=31, conflict=0 next cycle. Ra=5 with ba_out -> select=5.
- Conflict priority: out_req bits 17 and 21 with gra+r_out, Ra=4 -> select=4; next cycle conflict=1, sticky=1, count=1; err_clr then gives sticky=0, count=0.
- Saturation (macro defined, CNT_W=8): 300 consecutive conflict cycles -> count=255 and holds. Macro undefined -> count stays 0 while sticky=1.

Source files
------------

// File: rtl/bus_source_encoder_if.sv
// Bus-source encoder signal bundle: control-unit requests, IR capture and
// register-select controls in; mux select, register load strobes, C constant
// and conflict status out. master = control-unit side, slave = encoder side.
interface bus_source_encoder_if #(
  parameter int unsigned CNT_W = 8
);
  // Requests and IR handling from the control unit
  logic [23:0]      out_req;
  logic [31:0]      ir_in;
  logic             ir_load;
  logic             gra;
  logic             grb;
  logic             grc;
  logic             r_out;
  logic             ba_out;
  logic             r_in;
  logic             err_clr;
  // Encoder results
  logic [4:0]       select;
  logic [15:0]      reg_in;
  logic [31:0]      c_sign_extended;
  logic             conflict;
  logic             conflict_sticky;
  logic [CNT_W-1:0] conflict_count;

  modport master (
    output out_req, ir_in, ir_load, gra, grb, grc, r_out, ba_out, r_in, err_clr,
    input  select, reg_in, c_sign_extended, conflict, conflict_sticky, conflict_count
  );

  modport slave (
    input  out_req, ir_in, ir_load, gra, grb, grc, r_out, ba_out, r_in, err_clr,
    output select, reg_in, c_sign_extended, conflict, conflict_sticky, conflict_count
  );
endinterface

// File: rtl/bus_source_encoder.sv
// Bus source encoder: one-hot out requests plus IR-field register select are
// encoded into the 32:1 bus mux select; also drives register load strobes,
// the sign-extended C constant, and multi-driver conflict detection.
// Ports: clock, clear (async active-high), bus (bus_source_encoder_if.slave).
// Latency: select/reg_in/c_sign_extended combinational; conflict flags one cycle.
// Optional: BUS_SOURCE_ENCODER_CONFLICT_COUNT_EN adds the saturating counter;
// without it conflict_count is tied to zero.
module bus_source_encoder #(
  parameter int unsigned CNT_W    = 8,
  parameter logic [4:0]  IDLE_SEL = 5'd31
) (
  input logic                 clock,
  input logic                 clear,
  bus_source_encoder_if.slave bus
);

  logic [31:0] ir_q;
  logic [3:0]  fld;
  logic [15:0] fld_onehot;
  logic [15:0] rreq;
  logic [23:0] eff;
  logic        ba_zero;
  logic        multi;
  logic        cf_now;
  logic [4:0]  sel;
  logic        conflict_q;
  logic        sticky_q;

  // IR copy; fields loaded here only affect decode from the next cycle
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      ir_q <= '0;
    end else if (bus.ir_load) begin
      ir_q <= bus.ir_in;
    end
  end

  // Register field select, gra > grb > grc
  always_comb begin
    fld = 4'd0;
    if (bus.gra) begin
      fld = ir_q[26:23];
    end else if (bus.grb) begin
      fld = ir_q[22:19];
    end else if (bus.grc) begin
      fld = ir_q[18:15];
    end
  end

  assign fld_onehot = 16'd1 << fld;

  // BAout on R0 means "constant zero": no register-file request, bus idles to zero
  assign ba_zero = bus.ba_out && (fld == 4'd0);
  assign rreq    = (bus.r_out || (bus.ba_out && (fld != 4'd0))) ? fld_onehot : 16'd0;
  assign eff     = bus.out_req | {8'b0, rreq};

  // Lowest-index requester wins; scan downward so the lowest set bit is last written
  always_comb begin
    sel = IDLE_SEL;
    for (int i = 23; i >= 0; i--) begin
      if (eff[i]) begin
        sel = 5'(i);
      end
    end
  end

  // x & (x-1) clears the lowest set bit; anything left means two or more drivers
  assign multi  = |(eff & (eff - 24'd1));
  assign cf_now = multi || (ba_zero && (eff != 24'd0));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      conflict_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      conflict_q <= cf_now;
      // A fresh conflict beats err_clr in the same cycle
      sticky_q   <= cf_now | (sticky_q & ~bus.err_clr);
    end
  end

`ifdef BUS_SOURCE_ENCODER_CONFLICT_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (bus.err_clr) begin
      // Clearing in a conflict cycle still records that conflict
      cnt_q <= {{(CNT_W-1){1'b0}}, cf_now};
    end else if (cf_now && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.conflict_count = cnt_q;
`else
  assign bus.conflict_count = {CNT_W{1'b0}};
`endif

  assign bus.select          = sel;
  assign bus.reg_in          = bus.r_in ? fld_onehot : 16'd0;
  assign bus.c_sign_extended = {{13{ir_q[18]}}, ir_q[18:0]};
  assign bus.conflict        = conflict_q;
  assign bus.conflict_sticky = sticky_q;

endmodule
